cpu_job_sequencer: RTL and testbench



---
 rtl/cpu_job_pkg.sv | 20 ++
 rtl/job_watchdog.sv | 36 +++
 rtl/cpu_job_sequencer.sv | 156 +++++++++++++++
 tb/tb_cpu_job_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_job_pkg.sv
// Shared types and constants for the CPU job sequencer slice.
package cpu_job_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FIN
  } job_state_e;

  localparam logic [2:0]  FUNCT3_WORD = 3'b010;
  localparam int unsigned LOAD_WORDS  = 3;

  localparam logic [31:0] DEF_SP_ADDR     = 32'h0000_0400;
  localparam logic [31:0] DEF_EP_ADDR     = 32'h0000_0404;
  localparam logic [31:0] DEF_DONE_ADDR   = 32'h0000_0408;
  localparam int unsigned DEF_TIMEOUT_CYC = 200000;
  localparam int unsigned DEF_CNT_W       = 18;

endpackage

// File: rtl/job_watchdog.sv
// Run-time watchdog: counts enabled cycles from zero, flags the last allowed cycle.
module job_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter int unsigned CNT_W       = 18
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/cpu_job_sequencer.sv
// Runs one path-planning job on the core: preload memory, release the core,
// wait for the mailbox write or the watchdog, then hand the port to readback.
module cpu_job_sequencer
  import cpu_job_pkg::*;
#(
  parameter logic [31:0] SP_ADDR     = DEF_SP_ADDR,
  parameter logic [31:0] EP_ADDR     = DEF_EP_ADDR,
  parameter logic [31:0] DONE_ADDR   = DEF_DONE_ADDR,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  sp,
  input  logic [4:0]  ep,
  input  logic [31:0] rd_addr,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_funct3,
  output logic        cpu_rst,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_funct3,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] status
);

  job_state_e  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [4:0]  sp_q, sp_d, ep_q, ep_d;
  logic        done_q, done_d, timeout_q, timeout_d;
  logic [31:0] status_q, status_d;
  logic        in_run, wd_expire, mbox_hit;

  assign in_run   = (state_q == S_RUN);
  assign mbox_hit = cpu_we && (cpu_addr == DONE_ADDR) && (cpu_wdata != '0);

  job_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) u_wdog (
    .clk_i   (clk),
    .rst_i   (reset),
    .clear_i (!in_run),
    .en_i    (in_run),
    .expire_o(wd_expire)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sp_d      = sp_q;
    ep_d      = ep_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    status_d  = status_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (start) begin
          sp_d      = sp;
          ep_d      = ep;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          status_d  = '0;
          idx_d     = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (idx_q == 2'(LOAD_WORDS - 1)) begin
          idx_d   = '0;
          state_d = S_RUN;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      S_RUN: begin
        // A mailbox store on the watchdog's last cycle still counts as completion.
        if (mbox_hit) begin
          status_d = cpu_wdata;
          done_d   = 1'b1;
          state_d  = S_FIN;
        end else if (wd_expire) begin
          timeout_d = 1'b1;
          state_d   = S_FIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      sp_q      <= '0;
      ep_q      <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sp_q      <= sp_d;
      ep_q      <= ep_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      status_q  <= status_d;
    end
  end

  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = rd_addr;
    mem_wdata  = '0;
    mem_funct3 = FUNCT3_WORD;
    case (state_q)
      S_LOAD: begin
        mem_we = 1'b1;
        case (idx_q)
          2'd0: begin
            mem_addr  = SP_ADDR;
            mem_wdata = {27'b0, sp_q};
          end
          2'd1: begin
            mem_addr  = EP_ADDR;
            mem_wdata = {27'b0, ep_q};
          end
          default: begin
            mem_addr  = DONE_ADDR;
            mem_wdata = '0;
          end
        endcase
      end
      S_RUN: begin
        mem_we     = cpu_we;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        mem_funct3 = cpu_funct3;
      end
      default: ;
    endcase
  end

  assign cpu_rst = !in_run;
  assign busy    = (state_q == S_LOAD) || in_run;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign status  = status_q;

endmodule

// File: tb/tb_cpu_job_sequencer.sv
// Self-checking bench for cpu_job_sequencer with a job-level reference model.
module tb_cpu_job_sequencer;

  localparam int unsigned TO  = 16;
  localparam logic [31:0] SPA = 32'h0000_0400;
  localparam logic [31:0] EPA = 32'h0000_0404;
  localparam logic [31:0] DNA = 32'h0000_0408;

  logic        clk = 1'b0;
  logic        reset, start, cpu_we;
  logic [4:0]  sp, ep;
  logic [31:0] rd_addr, cpu_addr, cpu_wdata;
  logic [2:0]  cpu_funct3;
  logic        cpu_rst, mem_we, busy, done, timeout;
  logic [31:0] mem_addr, mem_wdata, status;
  logic [2:0]  mem_funct3;

  int n_assert = 0;
  int n_fail   = 0;

  // Mailbox stores for the next job: RUN-cycle offset and data.
  int          st_cyc[$];
  logic [31:0] st_data[$];

  cpu_job_sequencer #(
    .SP_ADDR    (SPA),
    .EP_ADDR    (EPA),
    .DONE_ADDR  (DNA),
    .TIMEOUT_CYC(TO),
    .CNT_W      (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sp        (sp),
    .ep        (ep),
    .rd_addr   (rd_addr),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_funct3(cpu_funct3),
    .cpu_rst   (cpu_rst),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_funct3(mem_funct3),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .status    (status)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle_cpu();
    cpu_we     = 1'b0;
    cpu_addr   = 32'h0000_0100 + ($urandom_range(0, 15) << 2);
    cpu_wdata  = $urandom;
    cpu_funct3 = 3'($urandom_range(0, 7));
  endtask

  task automatic chk_port_idle(input string tag);
    chk1({tag, "_we"}, mem_we, 1'b0);
    chk({tag, "_addr"}, mem_addr, rd_addr);
    chk({tag, "_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_f3"}, {29'b0, mem_funct3}, 32'h2);
    chk1({tag, "_cpurst"}, cpu_rst, 1'b1);
    chk1({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic run_job(input logic [4:0] s, input logic [4:0] e);
    int          r_end;
    bit          exp_done;
    logic [31:0] exp_status;
    logic [31:0] exp_addr, exp_data;
    exp_done   = 1'b0;
    exp_status = '0;
    r_end      = TO - 1;
    for (int r = 0; r < int'(TO) && !exp_done; r++)
      for (int k = 0; k < st_cyc.size(); k++)
        if (st_cyc[k] == r && st_data[k] != 0 && !exp_done) begin
          exp_done   = 1'b1;
          exp_status = st_data[k];
          r_end      = r;
        end

    // Request with a stray CPU store that must not reach memory.
    start = 1'b1; sp = s; ep = e;
    idle_cpu(); cpu_we = 1'b1; cpu_addr = DNA; cpu_wdata = 32'hFFFF;
    #1;
    chk1("pre_busy", busy, 1'b0);
    chk1("pre_we", mem_we, 1'b0);
    @(negedge clk);
    start = 1'b0; sp = ~s; ep = ~e;
    for (int i = 0; i < 3; i++) begin
      idle_cpu(); cpu_we = 1'b1;
      start = (i == 1);
      exp_addr = (i == 0) ? SPA : (i == 1) ? EPA : DNA;
      exp_data = (i == 0) ? {27'b0, s} : (i == 1) ? {27'b0, e} : 32'h0;
      #1;
      chk1("load_we", mem_we, 1'b1);
      chk("load_addr", mem_addr, exp_addr);
      chk("load_data", mem_wdata, exp_data);
      chk("load_f3", {29'b0, mem_funct3}, 32'h2);
      chk1("load_cpurst", cpu_rst, 1'b1);
      chk1("load_busy", busy, 1'b1);
      chk1("load_done", done, 1'b0);
      chk1("load_timeout", timeout, 1'b0);
      chk("load_status", status, 32'h0);
      @(negedge clk);
    end
    for (int r = 0; r <= r_end; r++) begin
      idle_cpu();
      for (int k = 0; k < st_cyc.size(); k++)
        if (st_cyc[k] == r) begin
          cpu_we = 1'b1; cpu_addr = DNA; cpu_wdata = st_data[k];
        end
      start = (r == 0);
      #1;
      chk1("run_cpurst", cpu_rst, 1'b0);
      chk1("run_busy", busy, 1'b1);
      chk1("run_we", mem_we, cpu_we);
      chk("run_addr", mem_addr, cpu_addr);
      chk("run_wdata", mem_wdata, cpu_wdata);
      chk("run_f3", {29'b0, mem_funct3}, {29'b0, cpu_funct3});
      chk1("run_done", done, 1'b0);
      chk1("run_timeout", timeout, 1'b0);
      @(negedge clk);
    end
    start = 1'b0;
    idle_cpu(); cpu_we = 1'b1; cpu_addr = DNA; cpu_wdata = 32'h77;
    rd_addr = 32'h0000_040C;
    #1;
    chk1("fin_done", done, exp_done);
    chk1("fin_timeout", timeout, !exp_done);
    chk("fin_status", status, exp_status);
    chk_port_idle("fin");
    @(negedge clk);
    idle_cpu(); rd_addr = $urandom;
    #1;
    chk1("fin_hold_done", done, exp_done);
    chk1("fin_hold_timeout", timeout, !exp_done);
    chk("fin_hold_addr", mem_addr, rd_addr);
    @(negedge clk);
  endtask

  initial begin
    int c;
    reset = 1'b1; start = 1'b0; sp = '0; ep = '0;
    rd_addr = 32'h0000_0500;
    idle_cpu();
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_cpurst", cpu_rst, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_timeout", timeout, 1'b0);
    chk("rst_status", status, 32'h0);
    chk_port_idle("rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Completion with status 9.
    st_cyc = {2}; st_data = {32'h0000_0009};
    run_job(5'd3, 5'd17);
    // Straight from FIN, no mailbox write: watchdog expiry.
    st_cyc.delete(); st_data.delete();
    run_job(5'd7, 5'd1);
    // Zero mailbox write ignored, later non-zero completes.
    st_cyc = {1, 3}; st_data = {32'h0, 32'h5};
    run_job(5'd12, 5'd30);
    // Completion on the watchdog's final cycle wins.
    st_cyc = {int'(TO) - 1}; st_data = {32'h0000_ABCD};
    run_job(5'd31, 5'd0);

    // Reset in the middle of LOAD.
    start = 1'b1; sp = 5'd9; ep = 5'd10; idle_cpu();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rl_mid_addr", mem_addr, EPA);
    @(negedge clk);
    reset = 1'b0; rd_addr = 32'h0000_0600;
    #1;
    chk_port_idle("rl_idle");
    chk1("rl_done", done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_cpu(); cpu_we = 1'b1;
      #1;
      chk1("rl_nowrite", mem_we, 1'b0);
    end
    @(negedge clk);

    // Randomised jobs.
    for (int j = 0; j < 8; j++) begin
      st_cyc.delete(); st_data.delete();
      c = -1;
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        c = c + int'($urandom_range(1, 7));
        st_cyc.push_back(c);
        st_data.push_back(($urandom_range(0, 1) == 0) ? 32'h0 : ($urandom | 32'h1));
      end
      run_job(5'($urandom), 5'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
